// File: rtl/dsram_responder.sv
// Data-side SRAM responder: accepts one load/store at a time, waits a fixed
// latency, then applies byte-strobed writes or returns registered read data.
module dsram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam state_t     ACC_STATE = (LATENCY == 1) ? S_RESP : S_WAIT;
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_wr;
    logic [3:0]          r_wstrb;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic                r_data_ok;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

    logic                w_addr_ok;
    logic                w_busy;
    logic                w_accept;
    logic                w_enter_resp;
    logic                w_op_wr;
    logic [3:0]          w_op_strb;
    logic [ADDR_W-1:0]   w_op_idx;
    logic [31:0]         w_op_wdata;
    logic                w_unused_addr;

    assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req) w_next = ACC_STATE;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP:  w_next = req ? ACC_STATE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr_ok = (r_state != S_WAIT);
        w_busy    = (r_state != S_IDLE);
    end

    assign w_accept     = req && w_addr_ok;
    assign w_enter_resp = !rst && (w_next == S_RESP);

    // With LATENCY==1 the response edge is the acceptance edge, so the
    // operation comes straight from the inputs rather than the latches.
    always_comb begin
        if (r_state == S_WAIT) begin
            w_op_wr    = r_wr;
            w_op_strb  = r_wstrb;
            w_op_idx   = r_idx;
            w_op_wdata = r_wdata;
        end else begin
            w_op_wr    = wr;
            w_op_strb  = wstrb;
            w_op_idx   = addr[ADDR_W+1:2];
            w_op_wdata = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_wr      <= 1'b0;
            r_wstrb   <= 4'd0;
            r_idx     <= '0;
            r_wdata   <= 32'h0;
            r_data_ok <= 1'b0;
            r_rdata   <= 32'h0;
        end else begin
            r_data_ok <= (w_next == S_RESP);
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_wr    <= wr;
                r_wstrb <= wstrb;
                r_idx   <= addr[ADDR_W+1:2];
                r_wdata <= wdata;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp && !w_op_wr)
                r_rdata <= r_mem[w_op_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_op_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_strb[i])
                    r_mem[w_op_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
            end
        end
    end

    assign addr_ok = w_addr_ok;
    assign busy    = w_busy;
    assign data_ok = r_data_ok;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder: instance 0 runs LATENCY=2, instance 1
// runs LATENCY=1; a reference memory predicts every load and every handshake.
module tb_dsram_responder;

    localparam int L0 = 2;
    localparam int L1 = 1;

    typedef struct {
        bit          wr;
        logic [9:0]  idx;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          due;
    } item_t;

    logic        clk;
    logic        rst;
    logic        req_i   [2];
    logic        wr_i    [2];
    logic [3:0]  strb_i  [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic        aok_o   [2];
    logic        dok_o   [2];
    logic [31:0] rd_o    [2];
    logic        busy_o  [2];

    int          n_chk;
    int          n_fail;
    int          cyc;
    bit          mon_en;
    item_t       q0[$];
    item_t       q1[$];
    logic [31:0] mm     [2][1024];
    logic [31:0] exp_rd [2];

    dsram_responder #(.ADDR_W(10), .LATENCY(L0)) u_dut (
        .clk(clk), .rst(rst), .req(req_i[0]), .wr(wr_i[0]), .wstrb(strb_i[0]),
        .addr(addr_i[0]), .wdata(wdata_i[0]), .addr_ok(aok_o[0]),
        .data_ok(dok_o[0]), .rdata(rd_o[0]), .busy(busy_o[0])
    );

    dsram_responder #(.ADDR_W(10), .LATENCY(L1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_i[1]), .wr(wr_i[1]), .wstrb(strb_i[1]),
        .addr(addr_i[1]), .wdata(wdata_i[1]), .addr_ok(aok_o[1]),
        .data_ok(dok_o[1]), .rdata(rd_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: sampled mid-cycle, so req&&addr_ok here is what the next edge accepts.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                bit    have;
                item_t it;
                have = 1'b0;
                if (k == 0) begin
                    if (q0.size() > 0) begin have = 1'b1; it = q0[0]; end
                end else begin
                    if (q1.size() > 0) begin have = 1'b1; it = q1[0]; end
                end
                if (dok_o[k]) begin
                    check_eq("dok_expected", 32'(have), 32'd1);
                    if (have) begin
                        check_eq("dok_cycle", 32'(cyc), 32'(it.due));
                        if (it.wr) begin
                            for (int b = 0; b < 4; b++)
                                if (it.strb[b]) mm[k][it.idx][8*b +: 8] = it.wdata[8*b +: 8];
                        end else begin
                            exp_rd[k] = mm[k][it.idx];
                        end
                        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    end
                    check_eq("addr_ok_resp", 32'(aok_o[k]), 32'd1);
                    check_eq("busy_resp", 32'(busy_o[k]), 32'd1);
                end else begin
                    if (have && cyc > it.due) begin
                        check_eq("dok_late", 32'(cyc), 32'(it.due));
                        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    end
                    check_eq("addr_ok", 32'(aok_o[k]), 32'(!have));
                    check_eq("busy", 32'(busy_o[k]), 32'(have));
                end
                check_eq("rdata", rd_o[k], exp_rd[k]);
                if (rst) begin
                    if (k == 0) q0.delete(); else q1.delete();
                    exp_rd[k] = 32'h0;
                end else if (req_i[k] && aok_o[k]) begin
                    it.wr    = wr_i[k];
                    it.idx   = addr_i[k][11:2];
                    it.strb  = strb_i[k];
                    it.wdata = wdata_i[k];
                    it.due   = cyc + ((k == 0) ? L0 : L1);
                    if (k == 0) q0.push_back(it); else q1.push_back(it);
                end
            end
        end
    end

    task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        req_i[k]   = r;
        wr_i[k]    = w;
        addr_i[k]  = a;
        strb_i[k]  = s;
        wdata_i[k] = d;
    endtask

    // Presents one request and returns just after the edge that accepted it.
    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        int n;
        n = 0;
        drive(k, 1'b1, w, a, s, d);
        @(negedge clk);
        while (!aok_o[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        drive(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        mon_en = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_eq("rst_addr_ok", 32'(aok_o[0]), 32'd1);
        check_eq("rst_data_ok", 32'(dok_o[0]), 32'd0);
        check_eq("rst_busy", 32'(busy_o[0]), 32'd0);
        check_eq("rst_rdata", rd_o[0], 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic store then load, LATENCY=2
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
        settle();
        check_eq("basic_load", rd_o[0], 32'hDEADBEEF);

        // Partial strobe merge
        issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
        issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        issue(0, 1'b0, 32'h20, 4'hF, 32'hFFFFFFFF);
        settle();
        check_eq("partial_load", rd_o[1-1], 32'h11BB33DD);

        // LATENCY=1 streaming, one acceptance per cycle
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            issue(1, 1'b1, 32'h100 + 32'(8*i), 4'hF, 32'hA5000000 + 32'(i));
            issue(1, 1'b0, 32'h100 + 32'(8*i), 4'h0, 32'h0);
        end
        check_eq("stream_cycles", 32'(cyc - c0), 32'd8);
        settle();
        check_eq("stream_last", rd_o[1], 32'hA5000003);

        // Address wrap and alignment, zero strobe
        issue(0, 1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A);
        issue(0, 1'b0, 32'h0003, 4'h0, 32'h0);
        settle();
        check_eq("wrap_load", rd_o[0], 32'h5A5A5A5A);
        issue(0, 1'b1, 32'h0, 4'h0, 32'hFFFFFFFF);
        issue(0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        check_eq("zero_strb_load", rd_o[0], 32'h5A5A5A5A);

        // Reset while a store is waiting
        issue(0, 1'b1, 32'h40, 4'hF, 32'h0);
        settle();
        issue(0, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_mid_addr_ok", 32'(aok_o[0]), 32'd1);
        check_eq("rst_mid_data_ok", 32'(dok_o[0]), 32'd0);
        settle();
        issue(0, 1'b0, 32'h40, 4'h0, 32'h0);
        settle();
        check_eq("rst_mid_load", rd_o[0], 32'h0);

        // Idle stability after a load
        issue(0, 1'b1, 32'h80, 4'hF, 32'h12345678);
        issue(0, 1'b0, 32'h80, 4'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("idle_rdata", rd_o[0], 32'h12345678);
        check_eq("idle_busy", 32'(busy_o[0]), 32'd0);
        check_eq("idle_data_ok", 32'(dok_o[0]), 32'd0);

        check_eq("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
